mc_ctrl: RTL and testbench
==========================

// Module: mc_ctrl
// PURPOSE
//  Multi-cycle MIPS control FSM sitting directly upstream of the ALU. Sequences each instruction through
//  FETCH/DECODE/EXEC/MEM/WB states and drives alu_op, shift-amount select, operand muxes, and PC/IR/RF/DM
//  write enables. Consumes the ALU's zero and dayuling (result > 0) flags to resolve beq/bgtz.
//  Also keeps a retired-instruction counter and flags illegal opcodes.
// PARAMETERS
//  CNT_W      32  width of instr_cnt
//  LUI_SHAMT  16  shift amount driven for lui (ALU op 2'b11, b<<s)
// PORTS
//  clk        in   1      system clock; single clock domain
//  reset      in   1      synchronous, active-high reset
//  opcode     in   6      IR[31:26], stable from DECODE until return to FETCH
//  funct      in   6      IR[5:0]
//  zero       in   1      ALU result == 0
//  dayuling   in   1      ALU result > 0 (signed)
//  pc_wr      out  1      PC write enable
//  pc_src     out  2      00 ALU result, 01 ALUOut reg (branch target), 10 {PC[31:28],IR[25:0],2'b00}, 11 rs
//  ir_wr      out  1      IR write enable
//  mem_wr     out  1      data-memory write enable
//  reg_wr     out  1      register-file write enable
//  reg_dst    out  2      00 rt, 01 rd, 10 $31
//  wd_sel     out  2      00 ALUOut, 01 MDR, 10 PC
//  alu_srca   out  1      0 PC, 1 rs
//  alu_srcb   out  2      00 rt, 01 const 4, 10 ext(imm), 11 ext(imm)<<2
//  ext_op     out  1      0 zero-extend, 1 sign-extend
//  alu_op     out  2      00 add, 01 sub, 10 or, 11 shift-left (b<<s)
//  shamt_sel  out  2      00 IR[10:6], 01 LUI_SHAMT, 10 zero
//  state      out  4      current state (debug)
//  illegal    out  1      one-cycle pulse in DECODE on unsupported opcode/funct
//  instr_cnt  out  CNT_W  retired-instruction count
// BEHAVIOUR
//  - Supported: addu subu sll jr (R), ori lw sw beq bgtz lui j jal. All others illegal.
//  - States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP.
//  - FETCH: ir_wr=1, pc_wr=1, pc_src=00, srca=0, srcb=01, alu_op=00 (PC+4). -> DECODE.
//  - DECODE: srca=0, srcb=11, ext_op=1, alu_op=00 (branch target into ALUOut). lw/sw->MEMADR;
//    R-ALU/ori/lui->EXEC; beq/bgtz->BRANCH; j/jal/jr->JUMP; illegal->FETCH with illegal=1.
//  - MEMADR: srca=1, srcb=10, ext_op=1, alu_op=00. lw->MEMRD, sw->MEMWR.
//  - MEMRD -> MEMWB. MEMWB: reg_wr=1, reg_dst=00, wd_sel=01. MEMWR: mem_wr=1.
//  - EXEC: addu srca=1 srcb=00 op=00; subu op=01; sll op=11 shamt_sel=00 srcb=00;
//    ori srcb=10 ext_op=0 op=10; lui srcb=10 ext_op=0 op=11 shamt_sel=01. -> ALUWB.
//  - ALUWB: reg_wr=1, wd_sel=00, reg_dst=01 for R-type, 00 for ori/lui.
//  - BRANCH: srca=1, srcb=00, alu_op=01, pc_src=01; pc_wr=zero (beq) or dayuling (bgtz; rt is $0).
//  - JUMP: j pc_src=10; jal pc_src=10 plus reg_wr=1 reg_dst=10 wd_sel=10; jr pc_src=11; pc_wr=1.
//  - Terminal states (MEMWB, MEMWR, ALUWB, BRANCH, JUMP) -> FETCH. CPI: lw 5, sw/ALU 4, br/jump 3.
//  - Unlisted select outputs in any state are 0.
//  - instr_cnt +1 on every terminal-state cycle; wraps 2^CNT_W-1 -> 0. Illegal not counted.
//  - Outputs are Moore (state) plus opcode/funct decode; no dependence on zero/dayuling except BRANCH pc_wr.
//  - Reset: state=FETCH, instr_cnt=0. While reset=1, pc_wr/ir_wr/mem_wr/reg_wr/illegal forced 0.
//    Reset mid-instruction aborts it: no further writes, not counted, first post-reset cycle is FETCH.
// STRUCTURE
//  - Package mc_ctrl_pkg: state encoding, opcode/funct constants, pc_src/reg_dst/wd_sel/srcb/alu_op/
//    shamt_sel encodings (shared with the datapath muxes and ALU).
//  - Sub-module mc_decode: combinational opcode/funct -> one-hot instruction class plus illegal.
//  - mc_ctrl holds state reg, next-state logic, output decode, and counter.
// TESTING
//  - Reset then addu: 4 cycles FETCH,DECODE,EXEC,ALUWB; ALUWB reg_wr=1 reg_dst=01; instr_cnt=1.
//  - lw then sw: lw 5 cycles with MEMWB wd_sel=01; sw 4 cycles with mem_wr=1 only in MEMWR; cnt=2.
//  - beq with zero=1 -> BRANCH pc_wr=1 pc_src=01. Same with zero=0 -> pc_wr=0. bgtz dayuling=1 -> pc_wr=1.
//  - lui: EXEC alu_op=11, shamt_sel=01, ext_op=0. jal: JUMP pc_wr=1 reg_wr=1 reg_dst=10 wd_sel=10.
//  - opcode 6'b111111: illegal pulses 1 cycle in DECODE, back to FETCH, cnt unchanged.
//  - Assert reset in MEMRD: next state FETCH, no reg_wr; counter preset near max wraps to 0 on retire.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path.
// Contents:
//   state_t      - FSM state encoding (also driven on the debug `state` port)
//   OP_* / FN_*  - opcode and R-type funct values of the supported instructions
//   PCSRC_*, RD_*, WD_*, SRCB_*, ALU_*, SH_* - select encodings shared with
//                  the datapath muxes and the ALU
//   instr_t      - one-hot instruction class produced by mc_decode
//   is_terminal  - true for the last state of every instruction
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;

    // PC source mux
    localparam logic [1:0] PCSRC_ALU     = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT  = 2'b01;
    localparam logic [1:0] PCSRC_JTARGET = 2'b10;
    localparam logic [1:0] PCSRC_RS      = 2'b11;

    // Register-file destination
    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    // Register-file write data
    localparam logic [1:0] WD_ALUOUT = 2'b00;
    localparam logic [1:0] WD_MDR    = 2'b01;
    localparam logic [1:0] WD_PC     = 2'b10;

    // ALU B operand
    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // ALU operation
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_SHL = 2'b11;

    // Shift amount source
    localparam logic [1:0] SH_IR   = 2'b00;
    localparam logic [1:0] SH_LUI  = 2'b01;
    localparam logic [1:0] SH_ZERO = 2'b10;

    typedef struct packed {
        logic addu;
        logic subu;
        logic sll;
        logic jr;
        logic ori;
        logic lw;
        logic sw;
        logic beq;
        logic bgtz;
        logic lui;
        logic j;
        logic jal;
    } instr_t;

    function automatic logic is_terminal(input state_t s);
        return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_ALUWB) ||
               (s == S_BRANCH) || (s == S_JUMP);
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier.
// Ports:
//   opcode  in  6   IR[31:26]
//   funct   in  6   IR[5:0], only meaningful for R-type
//   instr   out     one-hot instruction class (all zero when illegal)
//   illegal out 1   opcode/funct combination is not supported
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output instr_t     instr,
    output logic       illegal
);

    always_comb begin
        instr   = '0;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: instr.addu = 1'b1;
                    FN_SUBU: instr.subu = 1'b1;
                    FN_SLL:  instr.sll  = 1'b1;
                    FN_JR:   instr.jr   = 1'b1;
                    default: illegal    = 1'b1;
                endcase
            end
            OP_ORI:  instr.ori  = 1'b1;
            OP_LW:   instr.lw   = 1'b1;
            OP_SW:   instr.sw   = 1'b1;
            OP_BEQ:  instr.beq  = 1'b1;
            OP_BGTZ: instr.bgtz = 1'b1;
            OP_LUI:  instr.lui  = 1'b1;
            OP_J:    instr.j    = 1'b1;
            OP_JAL:  instr.jal  = 1'b1;
            default: illegal    = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM driving the ALU, operand muxes and the
// PC/IR/RF/DM write enables. Resolves beq/bgtz from the ALU flags, counts
// retired instructions and flags unsupported instructions.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   opcode, funct         IR fields, valid from DECODE until the next FETCH
//   zero, dayuling        ALU flags (result == 0, result > 0 signed)
//   pc_wr, ir_wr, mem_wr, reg_wr   write enables (held 0 while reset=1)
//   pc_src, reg_dst, wd_sel, alu_srca, alu_srcb, ext_op   datapath selects
//   alu_op, shamt_sel     ALU operation and shift-amount source
//   state                 current FSM state (debug)
//   illegal               one-cycle pulse in DECODE on an unsupported instruction
//   instr_cnt             retired-instruction count, wraps
// Handshake: none; the FSM advances every cycle. Outputs are a decode of the
// current state plus opcode/funct; only BRANCH's pc_wr looks at the ALU flags,
// because the compare is computed by the ALU in that same cycle.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int LUI_SHAMT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             dayuling,
    output logic             pc_wr,
    output logic [1:0]       pc_src,
    output logic             ir_wr,
    output logic             mem_wr,
    output logic             reg_wr,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wd_sel,
    output logic             alu_srca,
    output logic [1:0]       alu_srcb,
    output logic             ext_op,
    output logic [1:0]       alu_op,
    output logic [1:0]       shamt_sel,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    // The datapath applies LUI_SHAMT when shamt_sel selects it; it must be a
    // legal 5-bit shift.
    if (LUI_SHAMT < 1 || LUI_SHAMT > 31) begin : g_bad_lui_shamt
        $error("mc_ctrl: LUI_SHAMT must be in 1..31");
    end

    state_t state_q;
    instr_t instr;
    logic   dec_illegal;

    logic pc_wr_raw;
    logic ir_wr_raw;
    logic mem_wr_raw;
    logic reg_wr_raw;
    logic illegal_raw;

    mc_decode u_decode (
        .opcode  (opcode),
        .funct   (funct),
        .instr   (instr),
        .illegal (dec_illegal)
    );

    // State register, next-state logic and retired-instruction counter.
    // Reset always wins, so an instruction interrupted by reset is neither
    // completed nor counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instr_cnt <= '0;
        end else begin
            if (is_terminal(state_q))
                instr_cnt <= instr_cnt + CNT_W'(1);
            case (state_q)
                S_FETCH:  state_q <= S_DECODE;
                S_DECODE: begin
                    if (dec_illegal)
                        state_q <= S_FETCH;
                    else if (instr.lw || instr.sw)
                        state_q <= S_MEMADR;
                    else if (instr.addu || instr.subu || instr.sll || instr.ori || instr.lui)
                        state_q <= S_EXEC;
                    else if (instr.beq || instr.bgtz)
                        state_q <= S_BRANCH;
                    else
                        state_q <= S_JUMP;
                end
                S_MEMADR: state_q <= instr.lw ? S_MEMRD : S_MEMWR;
                S_MEMRD:  state_q <= S_MEMWB;
                S_EXEC:   state_q <= S_ALUWB;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    // Output decode; anything not set in a state stays at 0.
    always_comb begin
        pc_wr_raw   = 1'b0;
        ir_wr_raw   = 1'b0;
        mem_wr_raw  = 1'b0;
        reg_wr_raw  = 1'b0;
        illegal_raw = 1'b0;
        pc_src      = PCSRC_ALU;
        reg_dst     = RD_RT;
        wd_sel      = WD_ALUOUT;
        alu_srca    = 1'b0;
        alu_srcb    = SRCB_RT;
        ext_op      = 1'b0;
        alu_op      = ALU_ADD;
        shamt_sel   = SH_IR;
        case (state_q)
            S_FETCH: begin
                // PC <= PC + 4 while the instruction is latched into IR
                ir_wr_raw = 1'b1;
                pc_wr_raw = 1'b1;
                alu_srcb  = SRCB_FOUR;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut
                alu_srcb    = SRCB_IMM_SH2;
                ext_op      = 1'b1;
                illegal_raw = dec_illegal;
            end
            S_MEMADR: begin
                alu_srca = 1'b1;
                alu_srcb = SRCB_IMM;
                ext_op   = 1'b1;
            end
            S_MEMWB: begin
                reg_wr_raw = 1'b1;
                wd_sel     = WD_MDR;
            end
            S_MEMWR: mem_wr_raw = 1'b1;
            S_EXEC: begin
                alu_srca = 1'b1;
                if (instr.subu) begin
                    alu_op = ALU_SUB;
                end else if (instr.sll) begin
                    alu_op = ALU_SHL;
                end else if (instr.ori) begin
                    alu_srcb = SRCB_IMM;
                    alu_op   = ALU_OR;
                end else if (instr.lui) begin
                    alu_srcb  = SRCB_IMM;
                    alu_op    = ALU_SHL;
                    shamt_sel = SH_LUI;
                end
            end
            S_ALUWB: begin
                reg_wr_raw = 1'b1;
                reg_dst    = (instr.ori || instr.lui) ? RD_RT : RD_RD;
            end
            S_BRANCH: begin
                // rs - rt; bgtz has rt=$0 so dayuling reflects rs > 0
                alu_srca  = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PCSRC_ALUOUT;
                pc_wr_raw = instr.beq ? zero : dayuling;
            end
            S_JUMP: begin
                pc_wr_raw = 1'b1;
                if (instr.jr) begin
                    pc_src = PCSRC_RS;
                end else begin
                    pc_src = PCSRC_JTARGET;
                    if (instr.jal) begin
                        reg_wr_raw = 1'b1;
                        reg_dst    = RD_RA;
                        wd_sel     = WD_PC;
                    end
                end
            end
            default: ;
        endcase
    end

    assign pc_wr   = pc_wr_raw   & ~reset;
    assign ir_wr   = ir_wr_raw   & ~reset;
    assign mem_wr  = mem_wr_raw  & ~reset;
    assign reg_wr  = reg_wr_raw  & ~reset;
    assign illegal = illegal_raw & ~reset;
    assign state   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl. Counter width is reduced so the wrap is reachable.
module tb_mc_ctrl;

  localparam int CNT_W = 4;
  localparam int NV    = 16;

  logic             clk;
  logic             reset;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             dayuling;
  logic             pc_wr;
  logic [1:0]       pc_src;
  logic             ir_wr;
  logic             mem_wr;
  logic             reg_wr;
  logic [1:0]       reg_dst;
  logic [1:0]       wd_sel;
  logic             alu_srca;
  logic [1:0]       alu_srcb;
  logic             ext_op;
  logic [1:0]       alu_op;
  logic [1:0]       shamt_sel;
  logic [3:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] instr_cnt;

  mc_ctrl #(.CNT_W(CNT_W), .LUI_SHAMT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .dayuling  (dayuling),
    .pc_wr     (pc_wr),
    .pc_src    (pc_src),
    .ir_wr     (ir_wr),
    .mem_wr    (mem_wr),
    .reg_wr    (reg_wr),
    .reg_dst   (reg_dst),
    .wd_sel    (wd_sel),
    .alu_srca  (alu_srca),
    .alu_srcb  (alu_srcb),
    .ext_op    (ext_op),
    .alu_op    (alu_op),
    .shamt_sel (shamt_sel),
    .state     (state),
    .illegal   (illegal),
    .instr_cnt (instr_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, act=running req=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- vector table ----------------
  // Observation word: {state, pc_wr, pc_src, ir_wr, mem_wr, reg_wr, reg_dst,
  //                    wd_sel, alu_srca, alu_srcb, ext_op, alu_op, shamt_sel, illegal}
  typedef struct {
    logic [5:0]        op;
    logic [5:0]        fn;
    logic              z;
    logic              d;
    logic              ill;
    int                n;
    logic [4:0][22:0]  w;
  } vec_t;

  vec_t vt[NV];

  function automatic logic [22:0] mk(input int st, input int pcw, input int pcs, input int irw,
                                     input int memw, input int regw, input int rd, input int ws,
                                     input int sa, input int sb, input int ext, input int op,
                                     input int sh, input int ill);
    return {4'(st), 1'(pcw), 2'(pcs), 1'(irw), 1'(memw), 1'(regw), 2'(rd), 2'(ws),
            1'(sa), 2'(sb), 1'(ext), 2'(op), 2'(sh), 1'(ill)};
  endfunction

  task automatic set_v(input int i, input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic d, input logic ill, input int n, input logic [22:0] w0,
                       input logic [22:0] w1, input logic [22:0] w2, input logic [22:0] w3,
                       input logic [22:0] w4);
    vt[i].op  = op;
    vt[i].fn  = fn;
    vt[i].z   = z;
    vt[i].d   = d;
    vt[i].ill = ill;
    vt[i].n   = n;
    vt[i].w   = {w4, w3, w2, w1, w0};
  endtask

  // ---------------- scoreboard ----------------
  logic [22:0] exp_q[$];
  int          n_vec;
  int          n_err;
  logic [CNT_W-1:0] exp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: act=%0h req=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [22:0] e;
      logic [22:0] a;
      e = exp_q.pop_front();
      a = {state, pc_wr, pc_src, ir_wr, mem_wr, reg_wr, reg_dst, wd_sel,
           alu_srca, alu_srcb, ext_op, alu_op, shamt_sel, illegal};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL cycle_word: act=%06h req=%06h (state act=%0d req=%0d) at %0t",
                 a, e, a[22:19], e[22:19], $time);
      end
    end
  end

  // ---------------- driver ----------------
  // Entered and left at 1ns after a rising edge with the DUT in FETCH.
  // opcode/funct are garbage during FETCH and take the instruction from DECODE on.
  task automatic run_vec(input int i);
    for (int c = 0; c < vt[i].n; c++) exp_q.push_back(vt[i].w[c]);
    opcode   = 6'($urandom_range(0, 63));
    funct    = 6'($urandom_range(0, 63));
    zero     = vt[i].z;
    dayuling = vt[i].d;
    for (int c = 0; c < vt[i].n; c++) begin
      if (c == 1) begin
        opcode = vt[i].op;
        funct  = vt[i].fn;
      end
      @(posedge clk);
      #1;
    end
    if (!vt[i].ill) exp_cnt = exp_cnt + 1'b1;
    check($sformatf("cnt_after_vec%0d", i), 32'(instr_cnt), 32'(exp_cnt));
    check($sformatf("fetch_after_vec%0d", i), 32'(state), 32'd0);
  endtask

  logic [22:0] wf, wd, wdi, wma, wmr, wal_r, wal_i;

  initial begin
    n_vec    = 0;
    n_err    = 0;
    exp_cnt  = '0;
    reset    = 1'b1;
    opcode   = 6'd0;
    funct    = 6'd0;
    zero     = 1'b0;
    dayuling = 1'b0;

    //        st pcw pcs irw mw rw rd ws sa sb ext op sh ill
    wf    = mk(0, 1, 0,  1,  0, 0, 0, 0, 0, 1, 0,  0, 0, 0);
    wd    = mk(1, 0, 0,  0,  0, 0, 0, 0, 0, 3, 1,  0, 0, 0);
    wdi   = mk(1, 0, 0,  0,  0, 0, 0, 0, 0, 3, 1,  0, 0, 1);
    wma   = mk(2, 0, 0,  0,  0, 0, 0, 0, 1, 2, 1,  0, 0, 0);
    wmr   = mk(3, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0);
    wal_r = mk(7, 0, 0,  0,  0, 1, 1, 0, 0, 0, 0,  0, 0, 0);
    wal_i = mk(7, 0, 0,  0,  0, 1, 0, 0, 0, 0, 0,  0, 0, 0);

    // addu, subu, sll, jr
    set_v(0, 6'b000000, 6'b100001, 1, 1, 0, 4, wf, wd, mk(6,0,0,0,0,0,0,0,1,0,0,0,0,0), wal_r, '0);
    set_v(1, 6'b000000, 6'b100011, 0, 1, 0, 4, wf, wd, mk(6,0,0,0,0,0,0,0,1,0,0,1,0,0), wal_r, '0);
    set_v(2, 6'b000000, 6'b000000, 1, 0, 0, 4, wf, wd, mk(6,0,0,0,0,0,0,0,1,0,0,3,0,0), wal_r, '0);
    set_v(3, 6'b000000, 6'b001000, 0, 0, 0, 3, wf, wd, mk(9,1,3,0,0,0,0,0,0,0,0,0,0,0), '0, '0);
    // ori, lw, sw
    set_v(4, 6'b001101, 6'b101010, 1, 1, 0, 4, wf, wd, mk(6,0,0,0,0,0,0,0,1,2,0,2,0,0), wal_i, '0);
    set_v(5, 6'b100011, 6'b000111, 0, 0, 0, 5, wf, wd, wma, wmr, mk(4,0,0,0,0,1,0,1,0,0,0,0,0,0));
    set_v(6, 6'b101011, 6'b110011, 1, 1, 0, 4, wf, wd, wma, mk(5,0,0,0,1,0,0,0,0,0,0,0,0,0), '0);
    // beq taken / not taken (dayuling must not matter), bgtz taken / not taken
    set_v(7,  6'b000100, 6'b000000, 1, 0, 0, 3, wf, wd, mk(8,1,1,0,0,0,0,0,1,0,0,1,0,0), '0, '0);
    set_v(8,  6'b000100, 6'b000000, 0, 1, 0, 3, wf, wd, mk(8,0,1,0,0,0,0,0,1,0,0,1,0,0), '0, '0);
    set_v(9,  6'b000111, 6'b000000, 0, 1, 0, 3, wf, wd, mk(8,1,1,0,0,0,0,0,1,0,0,1,0,0), '0, '0);
    set_v(10, 6'b000111, 6'b000000, 1, 0, 0, 3, wf, wd, mk(8,0,1,0,0,0,0,0,1,0,0,1,0,0), '0, '0);
    // lui, j, jal
    set_v(11, 6'b001111, 6'b000000, 1, 1, 0, 4, wf, wd, mk(6,0,0,0,0,0,0,0,1,2,0,3,1,0), wal_i, '0);
    set_v(12, 6'b000010, 6'b000000, 0, 0, 0, 3, wf, wd, mk(9,1,2,0,0,0,0,0,0,0,0,0,0,0), '0, '0);
    set_v(13, 6'b000011, 6'b000000, 1, 1, 0, 3, wf, wd, mk(9,1,2,0,0,1,2,2,0,0,0,0,0,0), '0, '0);
    // illegal opcode, illegal R-type funct (add)
    set_v(14, 6'b111111, 6'b000000, 0, 0, 1, 2, wf, wdi, '0, '0, '0);
    set_v(15, 6'b000000, 6'b100000, 0, 0, 1, 2, wf, wdi, '0, '0, '0);

    // Reset held: FETCH would otherwise enable PC/IR writes.
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_cnt", 32'(instr_cnt), 32'd0);
    check("rst_wr_gated", {27'd0, pc_wr, ir_wr, mem_wr, reg_wr, illegal}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i);

    // lw interrupted by reset in MEMRD: aborted, not counted, counter cleared.
    opcode = 6'($urandom_range(0, 63));
    @(posedge clk); #1;
    opcode = 6'b100011;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("memrd_reached", 32'(state), 32'd3);
    reset = 1'b1;
    #1;
    check("memrd_rst_gated", {28'd0, pc_wr, ir_wr, mem_wr, reg_wr}, 32'd0);
    @(posedge clk); #1;
    check("memrd_rst_state", 32'(state), 32'd0);
    check("memrd_rst_cnt", 32'(instr_cnt), 32'd0);
    exp_cnt = '0;
    reset   = 1'b0;

    // Two more passes: 28 retirements wrap the 4-bit counter through 15 -> 0.
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < NV; i++) run_vec(i);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
